// File: rtl/bcd_counter_ndigit.sv
// bcd_counter_ndigit: prescaled N-digit BCD counter with preset, wrap pulse and 7-segment drive.
// Optional up/down counting via macro BCD_CNT_UPDOWN_EN (adds input dir).
module bcd_counter_ndigit #(
  parameter int DIGITS   = 2,
  parameter int TICK_DIV = 50000000
) (
  input  logic                  CLOCK_50,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  preset,
  input  logic [4*DIGITS-1:0]   preset_val,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [7*DIGITS-1:0]   hex,
  output logic                  tick,
  output logic                  wrap
`ifdef BCD_CNT_UPDOWN_EN
  ,
  input  logic                  dir
`endif
);
  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);
  logic [PW-1:0]         psc_q, psc_d;
  logic [4*DIGITS-1:0]   bcd_q, bcd_d, inc, load;
  logic                  tick_q, tick_d, wrap_q, wrap_d, step, cy, up;
  logic [3:0]            dig, pv;
`ifdef BCD_CNT_UPDOWN_EN
  assign up = dir;
`else
  assign up = 1'b1;
`endif
  // The count advances on the same edge that raises tick, so bcd, tick and wrap change together.
  assign tick_d = psc_q == LAST;
  assign psc_d  = tick_d ? '0 : psc_q + PW'(1);
  assign step   = tick_d & enable;
  always_comb begin
    cy   = 1'b1;
    inc  = '0;
    load = '0;
    dig  = '0;
    pv   = '0;
    for (int k = 0; k < DIGITS; k++) begin
      dig = bcd_q[4*k +: 4];
      pv  = preset_val[4*k +: 4];
      inc[4*k +: 4]  = !cy ? dig : up ? (dig == 4'd9 ? 4'd0 : dig + 4'd1)
                                      : (dig == 4'd0 ? 4'd9 : dig - 4'd1);
      cy = cy & (up ? dig == 4'd9 : dig == 4'd0);
      load[4*k +: 4] = pv > 4'd9 ? 4'd0 : pv;
    end
  end
  assign bcd_d  = preset ? load : step ? inc : bcd_q;
  assign wrap_d = !preset & step & cy;
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      psc_q  <= '0;
      bcd_q  <= '0;
      tick_q <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      psc_q  <= psc_d;
      bcd_q  <= bcd_d;
      tick_q <= tick_d;
      wrap_q <= wrap_d;
    end
  end
  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'h40;
      4'd1:    seg7 = 7'h79;
      4'd2:    seg7 = 7'h24;
      4'd3:    seg7 = 7'h30;
      4'd4:    seg7 = 7'h19;
      4'd5:    seg7 = 7'h12;
      4'd6:    seg7 = 7'h02;
      4'd7:    seg7 = 7'h78;
      4'd8:    seg7 = 7'h00;
      4'd9:    seg7 = 7'h10;
      default: seg7 = 7'h7F;
    endcase
  endfunction
  for (genvar i = 0; i < DIGITS; i++) begin : g_hex
    assign hex[7*i +: 7] = seg7(bcd_q[4*i +: 4]);
  end
  assign bcd  = bcd_q;
  assign tick = tick_q;
  assign wrap = wrap_q;
endmodule
